arbitro_memoria: RTL and testbench
==================================

ARBITRO_MEMORIA -- requirements
Module: arbitro_memoria

Interface
REQ-001 SHALL have parameter MAX_BURST, default 16: DMA beats allowed before forced CPU slot (used only with ARB_BURST_LIMIT_EN).
REQ-002 SHALL have port clk  in  1  single system clock; also drives memory wclk and rclk.
REQ-003 SHALL have port rst_n  in  1  synchronous reset, active-low.
REQ-004 SHALL have ports cpu_req/cpu_we  in  1/1  CPU access request / write enable.
REQ-005 SHALL have ports cpu_addr/cpu_wdata  in  10/32  CPU word address / write data.
REQ-006 SHALL have ports cpu_gnt  out  1, cpu_rvalid  out  1, cpu_rdata  out  32: grant, read-data valid, read data.
REQ-007 SHALL have ports dma_req/dma_we/dma_last  in  1/1/1  disk-DMA request / write enable / final beat of burst.
REQ-008 SHALL have ports dma_addr/dma_wdata  in  10/32; dma_gnt/dma_rvalid  out  1/1; dma_rdata  out  32.
REQ-009 SHALL have ports mem_endereco  out  10, mem_dado  out  32, mem_write  out  1, mem_saida  in  32 (256-word memory port).
REQ-010 SHALL have port addr_err  out  1  one-cycle pulse on an out-of-range access.

Function
REQ-011 SHALL grant at most one requester per cycle; gnt is combinational from req and registered arbiter state.
REQ-012 SHALL drive mem_endereco/mem_dado/mem_write from the granted port in the grant cycle; no grant -> mem_write 0, mem_endereco holds last value.
REQ-013 SHALL complete a granted write at the clk rising edge ending the grant cycle (write latency 0, no response).
REQ-014 SHALL register mem_saida at the rising edge ending a granted read and present it on the owner's rdata with rvalid high for exactly one cycle (read latency 1).
REQ-015 SHALL keep cpu_rdata/dma_rdata stable between rvalid pulses.
REQ-016 SHALL use states IDLE, CPU, DMA_BURST: IDLE/CPU -> DMA_BURST on a DMA grant with dma_last=0; DMA_BURST -> IDLE on a DMA beat with dma_last=1.
REQ-017 SHALL, in DMA_BURST, grant DMA whenever dma_req=1 and hold off the CPU, including cycles where dma_req drops (burst not abandoned).
REQ-018 SHALL, outside DMA_BURST with both requesting, grant the port not granted most recently (round-robin); single requester always wins.
REQ-019 SHALL treat cpu_addr/dma_addr[9:8] != 0 as out of range: mem_write forced 0, read returns rdata=0 with rvalid, addr_err pulses in the grant cycle; grant and burst state advance normally.
REQ-020 SHALL complete a read granted in the cycle before reset deassert-to-assert transition only if reset is not sampled low at that edge; reset wins.

Reset
REQ-021 SHALL, while rst_n=0 at a clk edge, force state IDLE, last-winner=DMA (CPU wins first conflict), beat counter 0, cpu_rvalid=dma_rvalid=0, cpu_rdata=dma_rdata=0, addr_err=0.
REQ-022 SHALL hold cpu_gnt=dma_gnt=mem_write=0 combinationally while rst_n=0.
REQ-023 SHALL abandon an in-flight burst on reset; no beat resumes afterwards.

Configuration
REQ-024 SHALL implement burst limiting only when ARB_BURST_LIMIT_EN is defined.
REQ-025 With ARB_BURST_LIMIT_EN: after MAX_BURST consecutive DMA beats in DMA_BURST with cpu_req=1, grant the CPU one beat, clear the counter, then resume DMA_BURST.
REQ-026 Without ARB_BURST_LIMIT_EN: no beat counter; DMA bursts are unbounded and CPU waits until dma_last.

Verification
REQ-027 Reset then cpu_req, cpu_we=0, addr 50 with memory[50]=16 -> cpu_gnt same cycle, cpu_rvalid=1, cpu_rdata=16 next cycle.
REQ-028 cpu_req and dma_req high together for 4 cycles, single beats -> grants alternate CPU,DMA,CPU,DMA.
REQ-029 DMA burst writes addr 100..103 (dma_last on 103) while cpu_req held -> cpu_gnt 0 for 4 cycles, then 1; memory[100..103] hold the written data.
REQ-030 CPU write to addr 300 -> mem_write=0, addr_err one-cycle pulse; CPU read to 300 -> cpu_rvalid=1, cpu_rdata=0.
REQ-031 With ARB_BURST_LIMIT_EN and MAX_BURST=4, 10-beat DMA burst plus constant cpu_req -> CPU granted after beats 4 and 8; without the macro -> CPU granted after beat 10.
REQ-032 rst_n low for one cycle during beat 2 of a burst -> all outputs at reset values; after release a CPU request is granted first.

Source files
------------

// File: rtl/arbitro_memoria.sv
// -----------------------------------------------------------------------------
// arbitro_memoria
//   Arbiter that lets the CPU and the disk DMA engine share one single-port,
//   256-word synchronous memory.  Grants are combinational from the request
//   lines and the registered arbiter state.  A granted write lands at the edge
//   that closes the grant cycle.  A granted read returns its data one cycle
//   later on the owner's rdata, with rvalid high for one cycle.
//
//   Arbitration: outside a DMA burst the two ports share round-robin, and a
//   single requester always wins.  Once the DMA starts a burst (a beat with
//   dma_last=0), it owns the memory until a beat with dma_last=1.
//
//   Optional feature (macro ARB_BURST_LIMIT_EN): after MAX_BURST DMA beats in a
//   burst, a waiting CPU gets one slot, then the burst resumes.  Without the
//   macro, bursts are unbounded.
//
// Ports
//   clk, rst_n                  clock (also the memory wclk/rclk), sync active-low reset
//   cpu_req/we/addr/wdata       CPU request side
//   cpu_gnt/rvalid/rdata        CPU grant and read response
//   dma_req/we/last/addr/wdata  DMA request side (dma_last marks the final beat)
//   dma_gnt/rvalid/rdata        DMA grant and read response
//   mem_endereco/dado/write     memory address / write data / write enable
//   mem_saida                   memory read data
//   addr_err                    pulses in the grant cycle of an out-of-range access
// -----------------------------------------------------------------------------
module arbitro_memoria #(
    parameter int MAX_BURST = 16,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [9:0]        cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic              dma_last,
    input  logic [9:0]        dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [9:0]        mem_endereco,
    output logic [DATA_W-1:0] mem_dado,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_saida,
    output logic              addr_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CPU       = 2'd1,
        DMA_BURST = 2'd2
    } state_t;

    state_t            state;
    logic              last_dma;        // 1 when the DMA won the most recent grant
    logic              force_cpu;
    logic              cpu_oor;
    logic              dma_oor;
    logic [9:0]        sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              sel_we;
    logic              sel_oor;
    logic [9:0]        addr_hold_p0;
    logic [DATA_W-1:0] data_hold_p0;
    logic              vld_cpu_p1;
    logic              vld_dma_p1;
    logic [DATA_W-1:0] cpu_rdata_p1;
    logic [DATA_W-1:0] dma_rdata_p1;

    // Only words 0..255 exist; any set bit above bit 7 is out of range.
    assign cpu_oor = (cpu_addr[9:8] != 2'b00);
    assign dma_oor = (dma_addr[9:8] != 2'b00);

`ifdef ARB_BURST_LIMIT_EN
    localparam int               CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    logic [CNT_W-1:0] beat_cnt_p0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_MAX) ? CNT_MAX : CNT_W'(v + 1'b1);
    endfunction

    // The CPU slot is taken only if the CPU is actually waiting; otherwise the
    // counter sits at its ceiling and the burst keeps going.
    assign force_cpu = (state == DMA_BURST) && cpu_req && (beat_cnt_p0 >= CNT_MAX);
`else
    logic unused_max_burst;
    assign unused_max_burst = (MAX_BURST > 0);
    assign force_cpu        = 1'b0;
`endif

    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (rst_n) begin
            if (state == DMA_BURST) begin
                // The burst owns the memory even in cycles where dma_req drops.
                if (force_cpu) cpu_gnt = 1'b1;
                else           dma_gnt = dma_req;
            end else if (cpu_req && dma_req) begin
                cpu_gnt = last_dma;
                dma_gnt = ~last_dma;
            end else begin
                cpu_gnt = cpu_req;
                dma_gnt = dma_req;
            end
        end
    end

    // Address and data hold their last granted values when nobody is granted.
    always_comb begin
        sel_addr = addr_hold_p0;
        sel_data = data_hold_p0;
        sel_we   = 1'b0;
        sel_oor  = 1'b0;
        if (cpu_gnt) begin
            sel_addr = cpu_addr;
            sel_data = cpu_wdata;
            sel_we   = cpu_we;
            sel_oor  = cpu_oor;
        end else if (dma_gnt) begin
            sel_addr = dma_addr;
            sel_data = dma_wdata;
            sel_we   = dma_we;
            sel_oor  = dma_oor;
        end
    end

    assign mem_endereco = sel_addr;
    assign mem_dado     = sel_data;
    assign mem_write    = sel_we & ~sel_oor;
    assign addr_err     = sel_oor;

    // ---- p0: memory-side hold registers (data path, not reset) ----
    always_ff @(posedge clk) begin
        if (cpu_gnt || dma_gnt) begin
            addr_hold_p0 <= sel_addr;
            data_hold_p0 <= sel_data;
        end
    end

    // ---- p1: arbiter state and read response ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_dma     <= 1'b1;
            vld_cpu_p1   <= 1'b0;
            vld_dma_p1   <= 1'b0;
            cpu_rdata_p1 <= '0;
            dma_rdata_p1 <= '0;
`ifdef ARB_BURST_LIMIT_EN
            beat_cnt_p0  <= '0;
`endif
        end else begin
            vld_cpu_p1 <= cpu_gnt & ~cpu_we;
            vld_dma_p1 <= dma_gnt & ~dma_we;
            if (cpu_gnt && !cpu_we) cpu_rdata_p1 <= cpu_oor ? '0 : mem_saida;
            if (dma_gnt && !dma_we) dma_rdata_p1 <= dma_oor ? '0 : mem_saida;

            if (cpu_gnt)      last_dma <= 1'b0;
            else if (dma_gnt) last_dma <= 1'b1;

            case (state)
                DMA_BURST: begin
                    if (dma_gnt && dma_last) state <= IDLE;
                end
                default: begin
                    if (dma_gnt)      state <= dma_last ? IDLE : DMA_BURST;
                    else if (cpu_gnt) state <= CPU;
                    else              state <= IDLE;
                end
            endcase

`ifdef ARB_BURST_LIMIT_EN
            // The opening beat of a burst counts as beat 1.
            if (dma_gnt)      beat_cnt_p0 <= dma_last ? '0 : sat_inc(beat_cnt_p0);
            else if (cpu_gnt) beat_cnt_p0 <= '0;
`endif
        end
    end

    assign cpu_rvalid = vld_cpu_p1;
    assign dma_rvalid = vld_dma_p1;
    assign cpu_rdata  = cpu_rdata_p1;
    assign dma_rdata  = dma_rdata_p1;

endmodule

// File: tb/tb_arbitro_memoria.sv
// -----------------------------------------------------------------------------
// tb_arbitro_memoria
//   Bench for arbitro_memoria.  It owns the 256-word memory (asynchronous
//   read, write at the clock edge).  A reference model checks every cycle:
//   grants, memory strobes, address holding and read responses.  The model
//   describes the arbiter in terms of "whose turn it is", "who owns the
//   memory" and a shadow copy of memory.  Directed scenarios come first, then
//   randomized traffic with occasional resets.
// -----------------------------------------------------------------------------
module tb_arbitro_memoria;
    localparam int TB_MAXB = 4;
`ifdef ARB_BURST_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [9:0]  cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_last, dma_gnt, dma_rvalid;
    logic [9:0]  dma_addr;
    logic [31:0] dma_wdata, dma_rdata;
    logic [9:0]  mem_endereco;
    logic [31:0] mem_dado, mem_saida;
    logic        mem_write, addr_err;

    arbitro_memoria #(.MAX_BURST(TB_MAXB)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_last(dma_last), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_endereco(mem_endereco), .mem_dado(mem_dado), .mem_write(mem_write),
        .mem_saida(mem_saida), .addr_err(addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory behind the arbiter.
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic        load_mem;

    assign mem_saida = mem[mem_endereco[7:0]];

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
        end else if (mem_write) begin
            mem[mem_endereco[7:0]] <= mem_dado;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    bit          m_owned_by_dma;   // a DMA burst currently owns the memory
    bit          m_cpu_turn;       // CPU wins the next conflict
    int          m_beats;          // DMA beats since the burst began or the last CPU slot
    bit          m_cpu_rv, m_dma_rv;
    logic [31:0] m_cpu_rd, m_dma_rd;
    logic [9:0]  m_last_addr;
    bit          m_addr_known;

    // Values seen in the last step, for the directed scenarios.
    bit obs_cpu_gnt, obs_dma_gnt, obs_err, obs_mw;

    logic [31:0] wd [4];
    int          nbeat, ncg, cg [3];
    bit          done;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: check outputs at the falling edge, advance the model at the rising edge.
    task automatic step();
        bit          ec, ed, eoor, ewe;
        logic [9:0]  ea;
        logic [31:0] ewd;
        @(negedge clk);
        ec = 1'b0;
        ed = 1'b0;
        if (rst_n) begin
            if (m_owned_by_dma) begin
                if (LIMIT && cpu_req && m_beats >= TB_MAXB) ec = 1'b1;
                else                                         ed = dma_req;
            end else if (cpu_req && dma_req) begin
                ec = m_cpu_turn;
                ed = !m_cpu_turn;
            end else begin
                ec = cpu_req;
                ed = dma_req;
            end
        end
        ea   = ec ? cpu_addr  : dma_addr;
        ewd  = ec ? cpu_wdata : dma_wdata;
        ewe  = ec ? cpu_we    : dma_we;
        eoor = (ec || ed) && (int'(ea) >= 256);

        obs_cpu_gnt = cpu_gnt;
        obs_dma_gnt = dma_gnt;
        obs_err     = addr_err;
        obs_mw      = mem_write;

        chk_eq("cpu_gnt", 32'(cpu_gnt), 32'(ec));
        chk_eq("dma_gnt", 32'(dma_gnt), 32'(ed));
        chk_eq("mem_write", 32'(mem_write), 32'((ec || ed) && ewe && !eoor));
        chk_eq("addr_err", 32'(addr_err), 32'(eoor));
        chk_eq("cpu_rvalid", 32'(cpu_rvalid), 32'(m_cpu_rv));
        chk_eq("dma_rvalid", 32'(dma_rvalid), 32'(m_dma_rv));
        chk_eq("cpu_rdata", cpu_rdata, m_cpu_rd);
        chk_eq("dma_rdata", dma_rdata, m_dma_rd);
        if (ec || ed) begin
            chk_eq("mem_endereco", 32'(mem_endereco), 32'(ea));
            chk_eq("mem_dado", mem_dado, ewd);
        end else if (m_addr_known) begin
            chk_eq("addr_hold", 32'(mem_endereco), 32'(m_last_addr));
        end

        @(posedge clk);
        if (!rst_n) begin
            m_owned_by_dma = 1'b0;
            m_cpu_turn     = 1'b1;
            m_beats        = 0;
            m_cpu_rv       = 1'b0;
            m_dma_rv       = 1'b0;
            m_cpu_rd       = '0;
            m_dma_rd       = '0;
        end else begin
            m_cpu_rv = ec && !cpu_we;
            m_dma_rv = ed && !dma_we;
            if (ec || ed) begin
                m_last_addr  = ea;
                m_addr_known = 1'b1;
                if (!ewe) begin
                    if (ec) m_cpu_rd = eoor ? 32'h0 : ref_mem[ea[7:0]];
                    else    m_dma_rd = eoor ? 32'h0 : ref_mem[ea[7:0]];
                end else if (!eoor) begin
                    ref_mem[ea[7:0]] = ewd;
                end
            end
            if (ec) begin
                m_cpu_turn = 1'b0;
                m_beats    = 0;
            end
            if (ed) begin
                m_cpu_turn = 1'b1;
                if (dma_last) begin
                    m_owned_by_dma = 1'b0;
                    m_beats        = 0;
                end else begin
                    m_owned_by_dma = 1'b1;
                    if (m_beats < TB_MAXB) m_beats++;
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        cpu_req  = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req  = 1'b0; dma_we = 1'b0; dma_last = 1'b0; dma_addr = '0; dma_wdata = '0;
    endtask

    task automatic cpu_drive(input bit we, input int a, input logic [31:0] d);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = 10'(a); cpu_wdata = d;
    endtask

    task automatic dma_drive(input bit we, input bit last, input int a, input logic [31:0] d);
        dma_req = 1'b1; dma_we = we; dma_last = last; dma_addr = 10'(a); dma_wdata = d;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    function automatic logic [9:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 10'($urandom_range(256, 1023));
        return 10'($urandom_range(0, 255));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-up: preload memory and hold reset.
        idle();
        rst_n    = 1'b0;
        load_mem = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
        ref_mem[50] = 32'd16;
        repeat (2) @(posedge clk);
        #1;
        load_mem       = 1'b0;
        m_owned_by_dma = 1'b0;
        m_cpu_turn     = 1'b1;
        m_beats        = 0;
        m_cpu_rv       = 1'b0;
        m_dma_rv       = 1'b0;
        m_cpu_rd       = '0;
        m_dma_rd       = '0;
        m_last_addr    = '0;
        m_addr_known   = 1'b0;

        chk_eq("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk_eq("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
        chk_eq("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk_eq("rst_dma_rdata", dma_rdata, 32'd0);

        // Requests during reset must not be granted or write memory.
        cpu_drive(1, 50, 32'hdead_beef);
        dma_drive(1, 0, 51, 32'h1234_5678);
        step();
        chk_eq("rst_no_cpu_gnt", 32'(obs_cpu_gnt), 32'd0);
        chk_eq("rst_no_dma_gnt", 32'(obs_dma_gnt), 32'd0);
        chk_eq("rst_no_write", 32'(obs_mw), 32'd0);
        idle();
        rst_n = 1'b1;

        // Read of word 50 (preloaded with 16).
        cpu_drive(0, 50, 0);
        step();
        chk_eq("rd50_gnt", 32'(obs_cpu_gnt), 32'd1);
        chk_eq("rd50_rvalid", 32'(cpu_rvalid), 32'd1);
        chk_eq("rd50_rdata", cpu_rdata, 32'd16);
        idle();
        step();
        chk_eq("rd50_rvalid_drop", 32'(cpu_rvalid), 32'd0);
        chk_eq("rd50_rdata_hold", cpu_rdata, 32'd16);

        // Round-robin with both requesting single beats: CPU, DMA, CPU, DMA.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cpu_drive(0, 10 + i, 0);
            dma_drive(0, 1, 20 + i, 0);
            step();
            chk_eq("rr_cpu", 32'(obs_cpu_gnt), 32'(i % 2 == 0));
            chk_eq("rr_dma", 32'(obs_dma_gnt), 32'(i % 2 == 1));
        end

        // DMA burst writes 100..103 while the CPU waits.
        do_reset();
        idle();
        cpu_drive(0, 1, 0);
        step();
        for (int i = 0; i < 4; i++) begin
            wd[i] = $urandom;
            cpu_drive(0, 5, 0);
            dma_drive(1, i == 3, 100 + i, wd[i]);
            step();
            chk_eq("burst_cpu_held", 32'(obs_cpu_gnt), 32'd0);
            chk_eq("burst_dma_beat", 32'(obs_dma_gnt), 32'd1);
        end
        idle();
        cpu_drive(0, 5, 0);
        step();
        chk_eq("burst_cpu_after", 32'(obs_cpu_gnt), 32'd1);
        for (int i = 0; i < 4; i++) chk_eq("burst_mem", mem[100 + i], wd[i]);

        // Out-of-range accesses.
        do_reset();
        cpu_drive(0, 50, 0);
        step();
        cpu_drive(1, 300, 32'hcafe_f00d);
        step();
        chk_eq("oor_wr_mw", 32'(obs_mw), 32'd0);
        chk_eq("oor_wr_err", 32'(obs_err), 32'd1);
        chk_eq("oor_mem44", mem[44], ref_mem[44]);
        cpu_drive(0, 300, 0);
        step();
        chk_eq("oor_rd_err", 32'(obs_err), 32'd1);
        chk_eq("oor_rd_rvalid", 32'(cpu_rvalid), 32'd1);
        chk_eq("oor_rd_rdata", cpu_rdata, 32'd0);
        idle();
        step();
        chk_eq("oor_err_clear", 32'(obs_err), 32'd0);

        // Ten-beat burst against a constantly requesting CPU.
        do_reset();
        cpu_drive(0, 1, 0);
        step();
        nbeat = 0;
        ncg   = 0;
        done  = 1'b0;
        for (int i = 0; i < 3; i++) cg[i] = -1;
        for (int c = 0; c < 40 && !done; c++) begin
            cpu_drive(0, 7, 0);
            if (nbeat < 10) dma_drive(1, nbeat == 9, 200 + nbeat, $urandom);
            else            dma_req = 1'b0;
            step();
            if (obs_cpu_gnt) begin
                if (ncg < 3) cg[ncg] = nbeat;
                ncg++;
                if (nbeat == 10) done = 1'b1;
            end
            if (obs_dma_gnt) nbeat++;
        end
        chk_eq("limit_beats", 32'(nbeat), 32'd10);
        chk_eq("limit_done", 32'(done), 32'd1);
`ifdef ARB_BURST_LIMIT_EN
        chk_eq("limit_cpu_slot1", 32'(cg[0]), 32'd4);
        chk_eq("limit_cpu_slot2", 32'(cg[1]), 32'd8);
`else
        chk_eq("nolimit_cpu_slot", 32'(cg[0]), 32'd10);
`endif

        // Reset during beat 2 of a burst.
        do_reset();
        cpu_drive(0, 50, 0);
        step();
        idle();
        dma_drive(0, 1, 51, 0);
        step();
        idle();
        dma_drive(1, 0, 60, 32'h0bad_0001);
        step();
        chk_eq("rb_beat1", 32'(obs_dma_gnt), 32'd1);
        cpu_drive(0, 61, 0);
        dma_drive(1, 0, 61, 32'h0bad_0002);
        rst_n = 1'b0;
        step();
        chk_eq("rb_rst_dma_gnt", 32'(obs_dma_gnt), 32'd0);
        chk_eq("rb_rst_cpu_gnt", 32'(obs_cpu_gnt), 32'd0);
        chk_eq("rb_rst_mw", 32'(obs_mw), 32'd0);
        chk_eq("rb_rst_err", 32'(obs_err), 32'd0);
        chk_eq("rb_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk_eq("rb_cpu_rdata", cpu_rdata, 32'd0);
        chk_eq("rb_dma_rdata", dma_rdata, 32'd0);
        rst_n = 1'b1;
        cpu_drive(0, 62, 0);
        dma_drive(1, 0, 62, 32'h0bad_0003);
        step();
        chk_eq("rb_cpu_first", 32'(obs_cpu_gnt), 32'd1);
        chk_eq("rb_dma_waits", 32'(obs_dma_gnt), 32'd0);

        // Randomized traffic.
        for (int c = 0; c < 2000; c++) begin
            rst_n     = ($urandom_range(0, 149) != 0);
            cpu_req   = ($urandom_range(0, 2) != 0);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = rand_addr();
            cpu_wdata = $urandom;
            dma_req   = ($urandom_range(0, 3) != 0);
            dma_we    = 1'($urandom_range(0, 1));
            dma_last  = ($urandom_range(0, 5) == 0);
            dma_addr  = rand_addr();
            dma_wdata = $urandom;
            step();
        end

        idle();
        rst_n = 1'b1;
        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
